// File: rtl/xor_checksum_acc.sv
// xor_checksum_acc: folds a valid/ready word stream into a per-packet XOR
// checksum and saturating word count, then holds the result until consumed.
//
// Ports:
//   clk        rising-edge system clock
//   rst_n      asynchronous active-low reset
//   in_valid   upstream word valid
//   in_ready   block can accept a word (low only while a result is held)
//   in_data    WIDTH-bit word folded into the checksum
//   in_last    marks in_data as the final word of the packet
//   out_valid  checksum result available
//   out_ready  downstream accepts the result
//   out_sum    XOR of all words in the packet
//   out_count  saturating word count of the packet
//   out_ovf    word count saturated during the packet
module xor_checksum_acc #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CNT_W-1:0] ocnt_q, ocnt_d;
   logic             oovf_q, oovf_d;

   logic             xfer;
   logic             cnt_max;
   logic [CNT_W-1:0] cnt_inc;
   logic [WIDTH-1:0] acc_x;

   assign in_ready  = (state_q != HOLD);
   assign out_valid = (state_q == HOLD);
   assign out_sum   = sum_q;
   assign out_count = ocnt_q;
   assign out_ovf   = oovf_q;

   assign xfer    = in_valid && in_ready;
   assign cnt_max = (cnt_q == {CNT_W{1'b1}});
   // acc and cnt are zero in IDLE, so one fold rule serves both states
   assign cnt_inc = cnt_max ? cnt_q : cnt_q + CNT_W'(1);
   assign acc_x   = acc_q ^ in_data;

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      sum_d   = sum_q;
      ocnt_d  = ocnt_q;
      oovf_d  = oovf_q;
      unique case (state_q)
         IDLE, ACCUM: begin
            if (xfer) begin
               if (in_last) begin
                  sum_d   = acc_x;
                  ocnt_d  = cnt_inc;
                  oovf_d  = ovf_q | cnt_max;
                  acc_d   = '0;
                  cnt_d   = '0;
                  ovf_d   = 1'b0;
                  state_d = HOLD;
               end else begin
                  acc_d   = acc_x;
                  cnt_d   = cnt_inc;
                  // sticky for the rest of the packet once the counter is full
                  ovf_d   = ovf_q | cnt_max;
                  state_d = ACCUM;
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         sum_q   <= '0;
         ocnt_q  <= '0;
         oovf_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         sum_q   <= sum_d;
         ocnt_q  <= ocnt_d;
         oovf_q  <= oovf_d;
      end
   end

endmodule

// File: tb/tb_xor_checksum_acc.sv
// tb_xor_checksum_acc: directed checks of xor_checksum_acc with two
// instances sharing stimulus (CNT_W = 8 and CNT_W = 2 for saturation).
module tb_xor_checksum_acc;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_last;
   logic       out_ready;

   logic       r1_in_ready, r1_valid, r1_ovf;
   logic [7:0] r1_sum, r1_count;
   logic       r2_in_ready, r2_valid, r2_ovf;
   logic [7:0] r2_sum;
   logic [1:0] r2_count;

   int total = 0;
   int pass  = 0;
   int fails = 0;

   xor_checksum_acc #(.WIDTH(8), .CNT_W(8)) u1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(r1_in_ready),
      .in_data(in_data), .in_last(in_last),
      .out_valid(r1_valid), .out_ready(out_ready),
      .out_sum(r1_sum), .out_count(r1_count), .out_ovf(r1_ovf)
   );

   xor_checksum_acc #(.WIDTH(8), .CNT_W(2)) u2 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(r2_in_ready),
      .in_data(in_data), .in_last(in_last),
      .out_valid(r2_valid), .out_ready(out_ready),
      .out_sum(r2_sum), .out_count(r2_count), .out_ovf(r2_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) pass++;
      else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [7:0] d,
                        input logic l);
      in_valid = v;
      in_data  = d;
      in_last  = l;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      out_ready = 1'b1;
      drive(1'b0, 8'h00, 1'b0);
      tick();
      tick();
      chk("rst_valid", 32'(r1_valid), 32'h0);
      chk("rst_sum",   32'(r1_sum),   32'h0);
      chk("rst_count", 32'(r1_count), 32'h0);
      chk("rst_ovf",   32'(r1_ovf),   32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("rel_ready", 32'(r1_in_ready), 32'h1);

      // 3-word packet, out_ready held high
      drive(1'b1, 8'h12, 1'b0);
      tick();
      drive(1'b1, 8'h34, 1'b0);
      tick();
      drive(1'b1, 8'h5C, 1'b1);
      tick();
      drive(1'b0, 8'h00, 1'b0);
      chk("p1_valid", 32'(r1_valid),    32'h1);
      chk("p1_sum",   32'(r1_sum),      32'h7A);
      chk("p1_count", 32'(r1_count),    32'h3);
      chk("p1_ovf",   32'(r1_ovf),      32'h0);
      chk("p1_rdy0",  32'(r1_in_ready), 32'h0);
      tick();
      chk("p1_vdrop", 32'(r1_valid),    32'h0);
      chk("p1_rdy1",  32'(r1_in_ready), 32'h1);
      chk("p1_hold",  32'(r1_sum),      32'h7A);

      // single-word packet, then backpressure with a pending word
      out_ready = 1'b0;
      drive(1'b1, 8'hA5, 1'b1);
      tick();
      chk("p2_valid", 32'(r1_valid), 32'h1);
      chk("p2_sum",   32'(r1_sum),   32'hA5);
      chk("p2_count", 32'(r1_count), 32'h1);
      drive(1'b1, 8'hFF, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("p2_bp_valid", 32'(r1_valid),    32'h1);
         chk("p2_bp_ready", 32'(r1_in_ready), 32'h0);
         chk("p2_bp_sum",   32'(r1_sum),      32'hA5);
      end
      out_ready = 1'b1;
      tick();
      chk("p2_rel_valid", 32'(r1_valid), 32'h0);
      chk("p2_rel_sum",   32'(r1_sum),   32'hA5);
      tick();
      drive(1'b0, 8'h00, 1'b0);
      chk("p2b_valid", 32'(r1_valid), 32'h1);
      chk("p2b_sum",   32'(r1_sum),   32'hFF);
      chk("p2b_count", 32'(r1_count), 32'h1);
      tick();

      // packet with an idle gap
      drive(1'b1, 8'h0F, 1'b0);
      tick();
      drive(1'b0, 8'hEE, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("p3_gap_valid", 32'(r1_valid),    32'h0);
         chk("p3_gap_ready", 32'(r1_in_ready), 32'h1);
      end
      drive(1'b1, 8'hF0, 1'b1);
      tick();
      drive(1'b0, 8'h00, 1'b0);
      chk("p3_valid", 32'(r1_valid), 32'h1);
      chk("p3_sum",   32'(r1_sum),   32'hFF);
      chk("p3_count", 32'(r1_count), 32'h2);
      chk("p3_ovf",   32'(r1_ovf),   32'h0);
      tick();

      // saturation: 5 words of 0x01
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 8'h01, (i == 4));
         tick();
      end
      drive(1'b0, 8'h00, 1'b0);
      chk("sat_valid",  32'(r2_valid), 32'h1);
      chk("sat_count",  32'(r2_count), 32'h3);
      chk("sat_ovf",    32'(r2_ovf),   32'h1);
      chk("sat_sum",    32'(r2_sum),   32'h01);
      chk("wide_count", 32'(r1_count), 32'h5);
      chk("wide_ovf",   32'(r1_ovf),   32'h0);
      tick();
      drive(1'b1, 8'h01, 1'b0);
      tick();
      drive(1'b1, 8'h01, 1'b1);
      tick();
      drive(1'b0, 8'h00, 1'b0);
      chk("sat2_count", 32'(r2_count), 32'h2);
      chk("sat2_ovf",   32'(r2_ovf),   32'h0);
      chk("sat2_sum",   32'(r2_sum),   32'h00);
      tick();

      // back-to-back packets: accumulator clears between them
      drive(1'b1, 8'hAA, 1'b0);
      tick();
      drive(1'b1, 8'h55, 1'b1);
      tick();
      drive(1'b0, 8'h00, 1'b0);
      chk("p5a_sum",   32'(r1_sum),   32'hFF);
      chk("p5a_count", 32'(r1_count), 32'h2);
      tick();
      drive(1'b1, 8'h80, 1'b1);
      tick();
      drive(1'b0, 8'h00, 1'b0);
      chk("p5b_sum",   32'(r1_sum),   32'h80);
      chk("p5b_count", 32'(r1_count), 32'h1);
      tick();

      // async reset mid-packet
      drive(1'b1, 8'h11, 1'b0);
      tick();
      drive(1'b1, 8'h22, 1'b0);
      tick();
      drive(1'b0, 8'h00, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_valid", 32'(r1_valid), 32'h0);
      chk("ar_sum",   32'(r1_sum),   32'h0);
      chk("ar_count", 32'(r1_count), 32'h0);
      tick();
      chk("ar_valid2", 32'(r1_valid), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("ar_rel_valid", 32'(r1_valid),    32'h0);
      chk("ar_rel_ready", 32'(r1_in_ready), 32'h1);
      drive(1'b1, 8'h33, 1'b1);
      tick();
      drive(1'b0, 8'h00, 1'b0);
      chk("ar_valid3", 32'(r1_valid), 32'h1);
      chk("ar_sum3",   32'(r1_sum),   32'h33);
      chk("ar_count3", 32'(r1_count), 32'h1);
      tick();

      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule

// File: doc/xor_checksum_acc.md
Name: xor_checksum_acc

Overview:
- Downstream consumer stage for the team's WIDTH-bit XOR datapath.
- Accepts a stream of WIDTH-bit words, such as XOR-gate results, over a valid/ready handshake, with packets delimited by in_last.
- Accumulates a running XOR checksum and word count per packet.
- Presents the result on a registered output handshake that holds until consumed.

Parameters:
- WIDTH, 8, data and checksum width in bits; must match the upstream XOR stage width.
- CNT_W, 8, width of the per-packet word counter.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word.
- in_data  input  WIDTH  word to fold into the checksum.
- in_last  input  1  qualifies in_data as the final word of the packet.
- out_valid  output  1  checksum result available.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  WIDTH  XOR of all words in the packet.
- out_count  output  CNT_W  number of words in the packet (saturating).
- out_ovf  output  1  word count saturated during this packet.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, internal acc = 0, cnt = 0, ovf_r = 0.
  - out_valid = 0, out_sum = 0, out_count = 0, out_ovf = 0.
  - in_ready = 1 one cycle after release; it is not forced low during reset beyond the IDLE decode.
- Input transfer occurs on a rising edge when in_valid && in_ready.
- in_ready = 1 in IDLE and ACCUM, 0 in HOLD. It is a combinational decode of the state register and has no combinational path from out_ready.
- States:
  - IDLE: no word of the current packet accepted yet; acc = 0, cnt = 0.
    - Transfer without last: acc <= in_data, cnt <= 1, go to ACCUM.
    - Transfer with last: go to HOLD.
  - ACCUM: one or more words accepted.
    - Transfer without last: acc <= acc ^ in_data, cnt <= cnt + 1 (saturating), stay in ACCUM.
    - Transfer with last: go to HOLD.
    - No transfer: hold all state. Idle gaps of any length are legal.
  - HOLD: out_valid = 1 and outputs stable.
    - When out_ready = 1 at an edge: out_valid <= 0, go to IDLE.
    - in_ready = 0 throughout HOLD, so there is exactly one bubble between packets minimum.
- On the last-word transfer (IDLE or ACCUM), in the same edge:
  - out_sum <= acc ^ in_data (acc is 0 in IDLE).
  - out_count <= sat(cnt + 1).
  - out_ovf <= ovf_r | (cnt + 1 overflow).
  - out_valid <= 1.
  - acc <= 0, cnt <= 0, ovf_r <= 0.
- Latency: result is visible one cycle after the last-word transfer edge.
- Saturation:
  - cnt stops at 2^CNT_W - 1.
  - Any accepted word beyond that sets ovf_r, which is sticky for the rest of the packet.
  - Checksum accumulation is unaffected by saturation.
- Output registers out_sum, out_count and out_ovf:
  - Hold their values after out_valid falls; they are not cleared on handshake.
  - Change only on the next last-word transfer.
- in_data and in_last are ignored when in_valid = 0 or in_ready = 0.
- out_ready is ignored outside HOLD.
- Reset asserted mid-packet or in HOLD:
  - Immediately returns the block to the reset values; the partial packet is discarded.
  - No out_valid pulse is produced for the discarded packet.

Test Plan:
- Reset, then 3-word packet 0x12, 0x34, 0x5C (last on 0x5C), with out_ready held 1 -> out_valid for exactly 1 cycle, out_sum = 0x7A, out_count = 3, out_ovf = 0. in_ready low exactly one cycle.
- Single-word packet 0xA5 with in_last = 1 from IDLE -> out_sum = 0xA5, out_count = 1. Then out_ready held 0 for 5 cycles -> out_valid stays 1, in_ready stays 0, and in_valid with 0xFF is not consumed until after out_ready = 1.
- Packet 0x0F, gap of 4 cycles with in_valid = 0, then 0xF0 with last -> out_sum = 0xFF, out_count = 2. Idle cycles have no effect.
- CNT_W = 2, packet of 5 words, all 0x01 -> out_count = 3, out_ovf = 1, out_sum = 0x01. Next 2-word packet 0x01, 0x01 -> out_ovf = 0, out_count = 2, out_sum = 0x00.
- Two packets in one run, 0xAA ^ 0x55 then 0x80 -> out_sum 0xFF then 0x80. Confirms acc clears between packets.
- Assert rst_n = 0 asynchronously after 2 words of a packet (0x11, 0x22), release, then send 0x33 with last -> out_sum = 0x33, out_count = 1, with no out_valid pulse for the aborted packet.
